// File: rtl/cache_perf_pkg.sv
// Shared types and helpers for the multi-channel cache performance monitor.
// Read-out select codes, FSM states and the channel-select width function.
package cache_perf_pkg;

  typedef enum logic [2:0] {
    SEL_RD           = 3'd0,
    SEL_WR           = 3'd1,
    SEL_RDH          = 3'd2,
    SEL_WRH          = 3'd3,
    SEL_CH_STALL     = 3'd4,
    SEL_GLOBAL_STALL = 3'd5,
    SEL_WIN_CNT      = 3'd6,
    SEL_OVF          = 3'd7
  } perf_sel_e;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } perf_state_e;

  // Number of per-channel counters; their index equals the rd_sel code 0..4.
  localparam int PER_CH_CNT = 5;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating event counter: holds at all-ones and flags increments it had to drop.
// count_next exposes the post-increment value so snapshots can capture it same-cycle.
module perf_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_next,
  output logic             sat_hit
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic sat;

  assign sat        = &count;
  assign sat_hit    = inc & sat;
  assign count_next = (inc && !sat) ? count + ONE : count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/cache_perf_monitor.sv
// Passive per-channel cache statistics: saturating counters, sticky overflow,
// windowed/manual shadow snapshots and a registered read-out port.
module cache_perf_monitor
  import cache_perf_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 32,
  parameter int WINDOW = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       clr,
  input  logic                       snap_req,
  input  logic [NUM_CH-1:0]          ch_read,
  input  logic [NUM_CH-1:0]          ch_write,
  input  logic [NUM_CH-1:0]          ch_hit,
  input  logic [NUM_CH-1:0]          ch_ready,
  input  logic [sel_w(NUM_CH)-1:0]   rd_ch,
  input  logic [2:0]                 rd_sel,
  input  logic                       rd_snap,
  output logic [CNT_W-1:0]           rd_data,
  output logic                       snap_valid,
  output logic [NUM_CH-1:0]          overflow,
  output perf_state_e                dbg_state
);

  localparam int NK = PER_CH_CNT;
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'((WINDOW > 0) ? WINDOW - 1 : 0);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  perf_state_e state, state_next;
  logic        active, win_end, snap, live_clr;

  logic [CNT_W-1:0] live     [NUM_CH][NK];
  logic [CNT_W-1:0] live_nxt [NUM_CH][NK];
  logic [CNT_W-1:0] shadow   [NUM_CH][NK];
  logic [NK-1:0]    inc      [NUM_CH];
  logic [NK-1:0]    sat_hits [NUM_CH];

  logic [CNT_W-1:0] gstall, gstall_nxt, shadow_gstall;
  logic [CNT_W-1:0] win_cnt, win_cnt_nxt;
  logic [CNT_W-1:0] win_done, win_done_nxt, shadow_win;
  logic             gstall_sat, win_sat;
  logic [CNT_W-1:0] rd_mux;
  logic             unused_ok;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en)  state_next = COUNT;
      COUNT:   if (!en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  assign dbg_state = state;

  // A cycle sampled with en=1 is counted, i.e. the cycle the FSM enters or stays in COUNT.
  assign active   = (state_next == COUNT);
  assign win_end  = active && (WINDOW > 0) && (win_cnt == WIN_LAST);
  assign snap     = snap_req | win_end;
  assign live_clr = clr | win_end;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign inc[c] = active ? {~ch_ready[c], ch_write[c] & ch_hit[c], ch_read[c] & ch_hit[c],
                              ch_write[c], ch_read[c]} : '0;
    for (genvar k = 0; k < NK; k++) begin : g_cnt
      perf_sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .clr        (live_clr),
        .inc        (inc[c][k]),
        .count      (live[c][k]),
        .count_next (live_nxt[c][k]),
        .sat_hit    (sat_hits[c][k])
      );
    end
  end

  perf_sat_counter #(.CNT_W(CNT_W)) u_gstall (
    .clk        (clk),
    .reset      (reset),
    .clr        (live_clr),
    .inc        (active & ~(&ch_ready)),
    .count      (gstall),
    .count_next (gstall_nxt),
    .sat_hit    (gstall_sat)
  );

  perf_sat_counter #(.CNT_W(CNT_W)) u_win (
    .clk        (clk),
    .reset      (reset),
    .clr        (live_clr),
    .inc        (active && (WINDOW > 0)),
    .count      (win_cnt),
    .count_next (win_cnt_nxt),
    .sat_hit    (win_sat)
  );

  // Global and window counters saturate silently.
  assign unused_ok = &{1'b0, gstall_sat, win_sat, win_cnt_nxt};

  assign win_done_nxt = (win_end && !(&win_done)) ? win_done + ONE : win_done;

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      overflow      <= '0;
      snap_valid    <= 1'b0;
      win_done      <= '0;
      shadow_gstall <= '0;
      shadow_win    <= '0;
      for (int c = 0; c < NUM_CH; c++)
        for (int k = 0; k < NK; k++)
          shadow[c][k] <= '0;
    end else begin
      snap_valid <= snap;
      win_done   <= win_done_nxt;
      for (int c = 0; c < NUM_CH; c++)
        overflow[c] <= overflow[c] | (|sat_hits[c]);
      if (snap) begin
        shadow_gstall <= gstall_nxt;
        shadow_win    <= win_done_nxt;
        for (int c = 0; c < NUM_CH; c++)
          for (int k = 0; k < NK; k++)
            shadow[c][k] <= live_nxt[c][k];
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    if (int'(rd_ch) < NUM_CH) begin
      case (perf_sel_e'(rd_sel))
        SEL_GLOBAL_STALL: rd_mux = rd_snap ? shadow_gstall : gstall;
        SEL_WIN_CNT:      rd_mux = rd_snap ? shadow_win : win_cnt;
        SEL_OVF:          rd_mux = CNT_W'(overflow);
        default:          rd_mux = rd_snap ? shadow[rd_ch][rd_sel] : live[rd_ch][rd_sel];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) rd_data <= '0;
    else        rd_data <= rd_mux;
  end

endmodule

// File: tb/tb_cache_perf_monitor.sv
// Bench for cache_perf_monitor: an 8-bit no-window instance and a 16-bit WINDOW=8
// instance share stimulus; read-outs are checked through an expected queue.
module tb_cache_perf_monitor;
  import cache_perf_pkg::*;

  logic       clk = 1'b0;
  logic       reset, en, clr, snap_req;
  logic [1:0] ch_read, ch_write, ch_hit, ch_ready;
  logic [0:0] rd_ch;
  logic [2:0] rd_sel;
  logic       rd_snap;

  logic [7:0]  rd_data0;
  logic [15:0] rd_data1;
  logic        snap_valid0, snap_valid1;
  logic [1:0]  ovf0, ovf1;
  perf_state_e st0, st1;

  int n_checks = 0;
  int n_pass   = 0;
  int pulses0  = 0;
  int pulses1  = 0;
  logic [15:0] exp_q[$];
  string       name_q[$];

  typedef struct {
    int          ch;
    int          sel;
    bit          snap;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  cache_perf_monitor #(.NUM_CH(2), .CNT_W(8), .WINDOW(0)) dut0 (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .snap_req(snap_req),
    .ch_read(ch_read), .ch_write(ch_write), .ch_hit(ch_hit), .ch_ready(ch_ready),
    .rd_ch(rd_ch), .rd_sel(rd_sel), .rd_snap(rd_snap),
    .rd_data(rd_data0), .snap_valid(snap_valid0), .overflow(ovf0), .dbg_state(st0)
  );

  cache_perf_monitor #(.NUM_CH(2), .CNT_W(16), .WINDOW(8)) dut1 (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .snap_req(snap_req),
    .ch_read(ch_read), .ch_write(ch_write), .ch_hit(ch_hit), .ch_ready(ch_ready),
    .rd_ch(rd_ch), .rd_sel(rd_sel), .rd_snap(rd_snap),
    .rd_data(rd_data1), .snap_valid(snap_valid1), .overflow(ovf1), .dbg_state(st1)
  );

  always @(negedge clk) begin
    if (snap_valid0) pulses0++;
    if (snap_valid1) pulses1++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    en = 1'b0; clr = 1'b0; snap_req = 1'b0;
    ch_read = '0; ch_write = '0; ch_hit = '0; ch_ready = 2'b11;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic rd(input int which, input int ch, input int sel, input bit snap,
                    input logic [15:0] exp, input string tag);
    logic [31:0] act;
    rd_ch = 1'(ch); rd_sel = 3'(sel); rd_snap = snap;
    exp_q.push_back(exp);
    name_q.push_back($sformatf("%s d%0d ch%0d sel%0d snap%0d", tag, which, ch, sel, snap));
    step();
    act = (which == 0) ? {24'h0, rd_data0} : {16'h0, rd_data1};
    check(name_q.pop_front(), act, {16'h0, exp_q.pop_front()});
  endtask

  initial begin
    int          b0, b1;
    int          m[2][5];
    int          mg;
    logic [20:0] pv, pe;
    int          ex[2][5];

    quiet();
    reset = 1'b0; rd_ch = '0; rd_sel = '0; rd_snap = 1'b0;

    // Reset with every strobe active
    en = 1'b1; snap_req = 1'b1; ch_read = 2'b11; ch_write = 2'b11; ch_hit = 2'b11; ch_ready = 2'b00;
    step(); step();
    check("reset rd_data", rd_data0, 0);
    check("reset snap_valid", snap_valid0 | snap_valid1, 0);
    check("reset overflow", {ovf1, ovf0}, 0);
    check("reset state", st0, IDLE);
    reset = 1'b1; en = 1'b0; snap_req = 1'b0;
    b0 = pulses0 + pulses1;
    repeat (10) step();
    check("idle state", st1, IDLE);
    for (int w = 0; w < 2; w++)
      for (int c = 0; c < 2; c++)
        for (int s = 0; s < 8; s++)
          for (int p = 0; p < 2; p++)
            rd(w, c, s, p[0], 16'd0, "idle");
    check("idle no snap pulse", pulses0 + pulses1 - b0, 0);

    // Basic counting, then a manual snapshot so live and shadow agree
    quiet(); pulse_clr();
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ch_read[0]  = (i < 7);
      ch_hit[0]   = (i < 7);
      ch_read[1]  = 1'b0;
      ch_write    = 2'b10;
      ch_hit[1]   = (i < 3);
      ch_ready[0] = 1'b1;
      ch_ready[1] = !(i >= 3 && i <= 6);
      step();
    end
    quiet();
    b0 = pulses0;
    snap_req = 1'b1; step(); snap_req = 1'b0; step();
    check("basic snap pulse", pulses0 - b0, 1);
    ex = '{'{7, 0, 7, 0, 0}, '{0, 10, 0, 3, 4}};
    tbl.delete();
    for (int c = 0; c < 2; c++)
      for (int k = 0; k < 5; k++)
        for (int p = 0; p < 2; p++)
          tbl.push_back('{ch: c, sel: k, snap: p[0], exp: 16'(ex[c][k])});
    tbl.push_back('{ch: 0, sel: 5, snap: 1'b0, exp: 16'd4});
    tbl.push_back('{ch: 1, sel: 5, snap: 1'b1, exp: 16'd4});
    tbl.push_back('{ch: 0, sel: 6, snap: 1'b0, exp: 16'd0});
    tbl.push_back('{ch: 0, sel: 7, snap: 1'b0, exp: 16'd0});
    foreach (tbl[i]) rd(0, tbl[i].ch, tbl[i].sel, tbl[i].snap, tbl[i].exp, "basic");

    // Random traffic against a behavioural model
    quiet(); pulse_clr();
    m = '{default: 0}; mg = 0;
    for (int i = 0; i < 60; i++) begin
      en       = ($urandom_range(0, 3) != 0);
      ch_read  = 2'($urandom_range(0, 3));
      ch_write = 2'($urandom_range(0, 3));
      ch_hit   = 2'($urandom_range(0, 3));
      ch_ready = 2'($urandom_range(0, 3));
      if (en) begin
        for (int c = 0; c < 2; c++) begin
          m[c][0] += int'(ch_read[c]);
          m[c][1] += int'(ch_write[c]);
          m[c][2] += int'(ch_read[c] & ch_hit[c]);
          m[c][3] += int'(ch_write[c] & ch_hit[c]);
          m[c][4] += int'(!ch_ready[c]);
        end
        if (ch_ready != 2'b11) mg++;
      end
      step();
    end
    quiet();
    for (int c = 0; c < 2; c++)
      for (int k = 0; k < 5; k++)
        rd(0, c, k, 1'b0, 16'(m[c][k]), "rand");
    rd(0, 0, 5, 1'b0, 16'(mg), "rand gstall");

    // Windowed snapshots on the WINDOW=8 instance
    quiet(); pulse_clr();
    en = 1'b1; ch_read = 2'b01;
    pv = '0;
    for (int i = 1; i <= 20; i++) begin
      step();
      pv[i] = snap_valid1;
    end
    quiet();
    pe = '0; pe[8] = 1'b1; pe[16] = 1'b1;
    check("window pulse cycles", pv, pe);
    rd(1, 0, 0, 1'b1, 16'd8, "win");
    rd(1, 0, 6, 1'b1, 16'd2, "win");
    rd(1, 0, 0, 1'b0, 16'd4, "win");
    rd(1, 0, 6, 1'b0, 16'd4, "win");
    rd(1, 0, 2, 1'b1, 16'd0, "win");
    rd(0, 0, 0, 1'b0, 16'd20, "nowin");

    // Saturation boundary on the 8-bit instance
    quiet(); pulse_clr();
    en = 1'b1; ch_read = 2'b01;
    repeat (255) step();
    quiet();
    rd(0, 0, 0, 1'b0, 16'd255, "sat at max");
    check("overflow at max", ovf0, 2'b00);
    en = 1'b1; ch_read = 2'b01;
    repeat (45) step();
    quiet();
    rd(0, 0, 0, 1'b0, 16'd255, "sat held");
    check("overflow sticky", ovf0, 2'b01);
    rd(0, 1, 7, 1'b0, 16'd1, "ovf vector");
    check("overflow wide inst", ovf1, 2'b00);
    pulse_clr();
    rd(0, 0, 0, 1'b0, 16'd0, "sat cleared");
    check("overflow cleared", ovf0, 2'b00);

    // clr beats a coincident snap_req
    quiet(); pulse_clr();
    en = 1'b1; ch_read = 2'b01;
    repeat (3) step();
    quiet();
    b1 = pulses1;
    clr = 1'b1; snap_req = 1'b1; step();
    clr = 1'b0; snap_req = 1'b0; step();
    check("clr+snap no pulse", pulses1 - b1, 0);
    rd(1, 0, 0, 1'b1, 16'd0, "clr+snap shadow");
    rd(1, 0, 0, 1'b0, 16'd0, "clr+snap live");

    // snap_req on the window-end cycle yields one pulse
    b0 = pulses0; b1 = pulses1;
    en = 1'b1; ch_read = 2'b01;
    for (int i = 1; i <= 8; i++) begin
      snap_req = (i == 8);
      step();
    end
    quiet(); step(); step();
    check("win+snap single pulse", pulses1 - b1, 1);
    check("manual snap pulse", pulses0 - b0, 1);
    rd(1, 0, 0, 1'b1, 16'd8, "win+snap");
    rd(1, 0, 6, 1'b1, 16'd1, "win+snap");
    rd(1, 0, 0, 1'b0, 16'd0, "win+snap");
    rd(0, 0, 0, 1'b1, 16'd8, "manual snap");

    // Reset in the middle of counting
    quiet(); pulse_clr();
    rd_ch = 1'b0; rd_sel = 3'd0; rd_snap = 1'b0;
    en = 1'b1; ch_read = 2'b01;
    repeat (50) step();
    reset = 1'b0; step();
    check("midrst rd_data", rd_data0, 0);
    check("midrst state", st0, IDLE);
    check("midrst snap_valid", snap_valid1, 0);
    reset = 1'b1; step();
    check("resume state", st0, COUNT);
    quiet();
    rd(0, 0, 0, 1'b0, 16'd1, "resume");
    rd(1, 0, 0, 1'b0, 16'd1, "resume");
    rd(1, 0, 6, 1'b1, 16'd0, "resume");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
